// File: rtl/fu_pkg.sv
// fu_pkg: shared functional-unit definitions (divider op encoding, default
// latency shared with the scoreboard delay table, divider FSM states).
package fu_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int unsigned FU_DIV_LATENCY_DEF = 24;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_CALC = 3'd1,
    DIV_FIX  = 3'd2,
    DIV_WAIT = 3'd3,
    DIV_DONE = 3'd4
  } div_state_t;

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    if (neg) begin
      cond_neg = 32'd0 - v;
    end else begin
      cond_neg = v;
    end
  endfunction

endpackage

// File: rtl/fu_div_step.sv
// div_step: one combinational restoring-division step (shift in one dividend
// bit, subtract the divisor if it fits).
module div_step (
  input  logic [32:0] rem_in,
  input  logic [31:0] divisor,
  input  logic        bit_in,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] shifted;
  logic [33:0] dvs;

  // Trial subtraction; keep the shifted remainder when the divisor does not fit.
  always_comb begin
    shifted = {rem_in, bit_in};
    dvs     = {2'b00, divisor};
    q_bit   = (shifted >= dvs);
    if (q_bit) begin
      rem_out = 33'(shifted - dvs);
    end else begin
      rem_out = shifted[32:0];
    end
  end

endmodule

// File: rtl/fu_div.sv
// fu_div: fixed-latency radix-4 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional rd-tag pass-through when FU_DIV_TAG_EN is defined.
module fu_div
  import fu_pkg::*;
#(
  parameter int unsigned LATENCY = FU_DIV_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [1:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] res,
  output logic        finish,
  output logic        busy
`ifdef FU_DIV_TAG_EN
  ,
  input  logic [4:0]  tag_in,
  output logic [4:0]  tag_out
`endif
);

  localparam logic [4:0] CALC_LAST = 5'd15;
  // cnt holds k-1 just before edge Ek, so DONE is entered at edge E(LATENCY-1).
  localparam logic [4:0] DONE_CNT  = 5'(LATENCY - 2);

  div_state_t  state;
  div_state_t  state_nxt;
  logic        accept;
  logic        load_res;
  logic [4:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic [31:0] result_q;
  logic        sgn;
  logic        neg_a;
  logic        neg_b;
  logic        op_rem;
  logic        div_zero;
  logic        ovf;
  logic        cap_sgn;
  logic [32:0] rem_mid;
  logic [32:0] rem_new;
  logic        q_hi;
  logic        q_lo;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] fix_res;

  assign cap_sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);

  div_step u_step_hi (
    .rem_in  (rem),
    .divisor (divisor),
    .bit_in  (quo[31]),
    .rem_out (rem_mid),
    .q_bit   (q_hi)
  );

  div_step u_step_lo (
    .rem_in  (rem_mid),
    .divisor (divisor),
    .bit_in  (quo[30]),
    .rem_out (rem_new),
    .q_bit   (q_lo)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; DONE accepts a new issue on its exit edge.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (EN) begin
          accept    = 1'b1;
          state_nxt = DIV_CALC;
        end else begin
          state_nxt = DIV_IDLE;
        end
      end
      DIV_CALC: begin
        if (cnt == CALC_LAST) begin
          state_nxt = DIV_FIX;
        end else begin
          state_nxt = DIV_CALC;
        end
      end
      DIV_FIX, DIV_WAIT: begin
        if (cnt == DONE_CNT) begin
          state_nxt = DIV_DONE;
        end else begin
          state_nxt = DIV_WAIT;
        end
      end
      DIV_DONE: begin
        if (EN) begin
          accept    = 1'b1;
          state_nxt = DIV_CALC;
        end else begin
          state_nxt = DIV_IDLE;
        end
      end
      default: begin
        state_nxt = DIV_IDLE;
      end
    endcase
    load_res = (state_nxt == DIV_DONE) && (state != DIV_DONE);
  end

  // Sign/special-case correction of the raw quotient and remainder.
  always_comb begin
    q_fix = quo;
    r_fix = rem[31:0];
    if (div_zero) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = cond_neg(rem[31:0], sgn & neg_a);
    end else if (ovf) begin
      q_fix = 32'h8000_0000;
      r_fix = 32'd0;
    end else begin
      q_fix = cond_neg(quo, sgn & (neg_a ^ neg_b));
      r_fix = cond_neg(rem[31:0], sgn & neg_a);
    end
    fix_res = op_rem ? r_fix : q_fix;
  end

  // Operand capture, radix-4 iteration and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 5'd0;
      rem      <= 33'd0;
      quo      <= 32'd0;
      divisor  <= 32'd0;
      result_q <= 32'd0;
      sgn      <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      op_rem   <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      cnt      <= 5'd0;
      rem      <= 33'd0;
      quo      <= cond_neg(rs1_data, cap_sgn & rs1_data[31]);
      divisor  <= cond_neg(rs2_data, cap_sgn & rs2_data[31]);
      sgn      <= cap_sgn;
      neg_a    <= cap_sgn & rs1_data[31];
      neg_b    <= cap_sgn & rs2_data[31];
      op_rem   <= (op == DIV_OP_REM) || (op == DIV_OP_REMU);
      div_zero <= (rs2_data == 32'd0);
      ovf      <= cap_sgn && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    end else begin
      if (state == DIV_CALC) begin
        rem <= rem_new;
        quo <= {quo[29:0], q_hi, q_lo};
      end
      if (state == DIV_FIX) begin
        result_q <= fix_res;
      end
      if ((state == DIV_CALC) || (state == DIV_FIX) || (state == DIV_WAIT)) begin
        cnt <= cnt + 5'd1;
      end
    end
  end

  // Registered outputs; with no WAIT cycles the result bypasses result_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res    <= 32'd0;
      finish <= 1'b0;
      busy   <= 1'b0;
    end else begin
      busy   <= (state_nxt != DIV_IDLE);
      finish <= (state_nxt == DIV_DONE);
      if (load_res) begin
        res <= (state == DIV_FIX) ? fix_res : result_q;
      end
    end
  end

`ifdef FU_DIV_TAG_EN
  logic [4:0] tag_q;

  // Tag follows the operands in and the result out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= 5'd0;
      tag_out <= 5'd0;
    end else begin
      if (accept) begin
        tag_q <= tag_in;
      end
      if (load_res) begin
        tag_out <= tag_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fu_div.sv
// tb_fu_div: directed self-checking bench for fu_div (LATENCY = 24).
module tb_fu_div;

  localparam int LAT = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] res;
  logic        finish;
  logic        busy;
`ifdef FU_DIV_TAG_EN
  logic [4:0]  tag_in;
  logic [4:0]  tag_out;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [31:0] prev;
  logic        saw_finish;

  always #5 clk = ~clk;

  fu_div #(.LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (EN),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .res      (res),
    .finish   (finish),
    .busy     (busy)
`ifdef FU_DIV_TAG_EN
    ,
    .tag_in   (tag_in),
    .tag_out  (tag_out)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one issue; returns at E0+1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    EN       = 1'b1;
    op       = o;
    rs1_data = a;
    rs2_data = b;
    step();
    EN       = 1'b0;
  endtask

  // From E0+1 advance to E(LAT-1)+1, checking the whole pulse window.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int spur_k);
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_fin_e0"}, {31'd0, finish}, 32'd0);
    for (int k = 1; k <= LAT - 2; k++) begin
      if (k == spur_k) begin
        EN       = 1'b1;
        op       = 2'b00;
        rs1_data = 32'd5;
        rs2_data = 32'd1;
      end
      step();
      EN = 1'b0;
      chk({tag, "_fin_early"}, {31'd0, finish}, 32'd0);
      chk({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
      chk({tag, "_res_hold"}, res, prev);
    end
    step();
    chk({tag, "_fin"}, {31'd0, finish}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    chk({tag, "_res"}, res, exp);
`ifdef FU_DIV_TAG_EN
    chk({tag, "_tag"}, {27'd0, tag_out}, 32'd17);
`endif
  endtask

  // DONE -> IDLE edge with no new issue.
  task automatic retire(input string tag, input logic [31:0] exp);
    step();
    chk({tag, "_fin_drop"}, {31'd0, finish}, 32'd0);
    chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    chk({tag, "_res_keep"}, res, exp);
    prev = exp;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(o, a, b);
    wait_done(tag, exp, 0);
    retire(tag, exp);
  endtask

  initial begin
    rst      = 1'b1;
    EN       = 1'b0;
    op       = 2'b00;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    prev     = 32'd0;
`ifdef FU_DIV_TAG_EN
    tag_in   = 5'd17;
`endif
    step();
    step();
    chk("rst_res", res, 32'd0);
    chk("rst_fin", {31'd0, finish}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();

    run_op("div_100_7",    2'b00, 32'd100,        32'd7,          32'd14);
    run_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    run_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    run_op("div_100_m7",   2'b00, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2);
    run_op("rem_100_m7",   2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2);
    run_op("divu_by0",     2'b01, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF);
    run_op("remu_by0",     2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678);
    run_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    run_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
    run_op("divu_big",     2'b01, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF);

    // Abort mid-operation.
    issue(2'b01, 32'd50, 32'd5);
    for (int k = 0; k < 9; k++) step();
    rst = 1'b1;
    #1;
    chk("abort_res", res, 32'd0);
    chk("abort_fin", {31'd0, finish}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    saw_finish = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      saw_finish = saw_finish | finish | busy;
    end
    chk("abort_quiet", {31'd0, saw_finish}, 32'd0);
    prev = 32'd0;
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3);

    // Back-to-back: second issue sampled on the DONE exit edge, spurious EN mid-op.
    issue(2'b01, 32'd1000, 32'd10);
    wait_done("b2b_a", 32'd100, 0);
    prev = 32'd100;
    issue(2'b01, 32'd77, 32'd7);
    chk("b2b_fin_drop", {31'd0, finish}, 32'd0);
    chk("b2b_res_keep", res, 32'd100);
    wait_done("b2b_b", 32'd11, 5);
    retire("b2b_b", 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
